// File: rtl/neuro_pkg.sv
// Shared definitions for the neuro_mac_engine slice.
// Holds the register map, cache-select codes, FSM state encoding,
// accumulator width derivation and the shift/saturate helper.
package neuro_pkg;

  localparam logic [15:0] REG_OFF    = 16'h8000;
  localparam logic [15:0] REG_DEST   = 16'h8001;
  localparam logic [15:0] REG_NOPS   = 16'h8002;
  localparam logic [15:0] REG_CSEL   = 16'h8003;
  localparam logic [15:0] REG_CTRL   = 16'h8004;
  localparam logic [15:0] REG_STATUS = 16'h8005;

  localparam int CSEL_L  = 0;
  localparam int CSEL_I  = 1;
  localparam int CSEL_O  = 2;
  localparam int CSEL_W0 = 3;

  // Wide enough to hold any accumulator this block can be built with.
  localparam int SAT_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IDX,
    ST_OPR,
    ST_MAC,
    ST_WB
  } state_t;

  // Full product width plus AW guard bits: DEPTH products cannot overflow.
  function automatic int acc_width(input int data_w, input int aw);
    return 2 * data_w + aw;
  endfunction

  // Drop frac_w fraction bits (arithmetic shift, rounds toward -inf) and
  // clamp to the signed data_w-bit range.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int                      frac_w,
    input int                      data_w
  );
    logic signed [SAT_W-1:0] sh;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] hi;
    sh = acc >>> frac_w;
    lo = -(128'sd1 <<< (data_w - 1));
    hi = (128'sd1 <<< (data_w - 1)) - 128'sd1;
    if (sh > hi)      return hi;
    else if (sh < lo) return lo;
    else              return sh;
  endfunction

endpackage

// File: rtl/neuro_mac_lane.sv
// One neuron channel: weight bank, multiply, accumulate and the
// shift/saturate (plus optional ReLU) writeback value.
// Optional feature macro: NEURO_RELU_EN clamps negative results to 0.
module neuro_mac_lane
  import neuro_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_haddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [AW-1:0]            i_eaddr,
  input  logic signed [DATA_W-1:0] i_l_p1,
  input  logic                     i_acc_clr,
  input  logic                     i_acc_en,
  output logic [DATA_W-1:0]        o_hrdata,
  output logic [DATA_W-1:0]        o_wb
);

  localparam int ACC_W = acc_width(DATA_W, AW);

  logic [DATA_W-1:0]          r_mem [DEPTH];
  logic signed [DATA_W-1:0]   r_w_p1;
  logic signed [2*DATA_W-1:0] w_prod_p2;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [DATA_W-1:0]   w_sat;

  // Weight bank: host write port plus an engine read registered for the MAC stage.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_haddr] <= i_wdata;
    r_w_p1 <= r_mem[i_eaddr];
  end

  assign o_hrdata = r_mem[i_haddr];

  // ---- stage p1 -> p2: operands registered, full-precision product ----
  assign w_prod_p2 = r_w_p1 * i_l_p1;

  // Accumulator: cleared when an operation is accepted, summed in MAC cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_acc <= '0;
    else if (i_acc_clr) r_acc <= '0;
    else if (i_acc_en)  r_acc <= r_acc + {{AW{w_prod_p2[2*DATA_W-1]}}, w_prod_p2};
  end

  // ---- writeback value: fixed-point realign and clamp ----
  assign w_sat = DATA_W'(sat_shift(SAT_W'(r_acc), FRAC_W, DATA_W));

`ifdef NEURO_RELU_EN
  assign o_wb = w_sat[DATA_W-1] ? '0 : w_sat;
`else
  assign o_wb = w_sat;
`endif

endmodule

// File: rtl/neuro_mac_engine.sv
// Memory-mapped multi-channel fixed-point dot-product engine.
// Register file, L/I/O caches, sequencing FSM and host read mux; one
// neuro_mac_lane per channel holds the weights and accumulator.
// Optional feature macro: NEURO_RELU_EN (ReLU on writeback, STATUS bit1).
module neuro_mac_engine
  import neuro_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int DEPTH  = 256,
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StartOperation,
  input  logic              WE,
  input  logic [15:0]       Address,
  input  logic [DATA_W-1:0] DataWrite,
  output logic [DATA_W-1:0] DataRead,
  output logic              ReadyNextOperation
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = (DATA_W < 16) ? DATA_W : 16;
  localparam int KW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef NEURO_RELU_EN
  localparam logic RELU_FLAG = 1'b1;
`else
  localparam logic RELU_FLAG = 1'b0;
`endif

  logic [DATA_W-1:0] r_off, r_dest, r_nops, r_csel, r_ctrl;
  state_t            r_state;
  logic              r_ready;
  logic [NW-1:0]     r_i;
  logic [KW-1:0]     r_k;

  logic [DATA_W-1:0] r_l_mem [DEPTH];
  logic [DATA_W-1:0] r_i_mem [DEPTH];
  logic [DATA_W-1:0] r_o_mem [DEPTH];

  logic [AW-1:0]            r_idx_p0;
  logic signed [DATA_W-1:0] r_l_p1;

  logic [NW-1:0]     w_n;
  logic              w_host_wr;
  logic              w_cache_wr;
  logic [AW-1:0]     w_haddr;
  logic [AW-1:0]     w_eaddr;
  logic              w_acc_clr;
  logic              w_acc_en;
  logic              w_wb_we;
  logic [AW-1:0]     w_wb_addr;
  logic [DATA_W-1:0] w_hrd [NUM_CH];
  logic [DATA_W-1:0] w_wb  [NUM_CH];
  logic [DATA_W-1:0] w_rd;

  assign w_n        = r_nops[NW-1:0];
  assign w_host_wr  = WE && r_ready;
  assign w_cache_wr = w_host_wr && !Address[15];
  assign w_haddr    = Address[AW-1:0];
  assign w_eaddr    = r_off[AW-1:0] + AW'(r_i);
  assign w_acc_clr  = (r_state == ST_IDLE) && StartOperation;
  assign w_acc_en   = (r_state == ST_MAC);
  assign w_wb_we    = (r_state == ST_WB) && r_ctrl[r_k];
  assign w_wb_addr  = r_dest[AW-1:0] + AW'(r_k);

  assign ReadyNextOperation = r_ready;

  // Host-visible configuration registers; writes only land while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_off  <= '0;
      r_dest <= '0;
      r_nops <= '0;
      r_csel <= '0;
      r_ctrl <= '0;
    end else if (w_host_wr) begin
      case (Address)
        REG_OFF:  r_off  <= DataWrite;
        REG_DEST: r_dest <= DataWrite;
        REG_NOPS: r_nops <= DataWrite;
        REG_CSEL: r_csel <= DataWrite;
        REG_CTRL: r_ctrl <= DataWrite;
        default:  ;
      endcase
    end
  end

  // Sequencer: per input IDX -> OPR -> MAC, then one WB cycle per channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_i     <= '0;
      r_k     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (StartOperation) begin
            r_i     <= '0;
            r_k     <= '0;
            r_ready <= 1'b0;
            r_state <= (w_n == '0) ? ST_WB : ST_IDX;
          end
        end
        ST_IDX: r_state <= ST_OPR;
        ST_OPR: r_state <= ST_MAC;
        ST_MAC: begin
          if ((r_i + NW'(1)) < w_n) begin
            r_i     <= r_i + NW'(1);
            r_state <= ST_IDX;
          end else begin
            r_state <= ST_WB;
          end
        end
        ST_WB: begin
          if (r_k == KW'(NUM_CH - 1)) begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // L cache: host write port, engine read of the indexed activation.
  always_ff @(posedge clk) begin
    if (w_cache_wr && (r_csel == DATA_W'(CSEL_L))) r_l_mem[w_haddr] <= DataWrite;
    // ---- stage p0 -> p1: index resolved, activation fetched ----
    r_l_p1 <= r_l_mem[r_idx_p0];
  end

  // I cache: host write port, engine read of the index (truncated to AW bits).
  always_ff @(posedge clk) begin
    if (w_cache_wr && (r_csel == DATA_W'(CSEL_I))) r_i_mem[w_haddr] <= DataWrite;
    // ---- stage p0: index fetch ----
    r_idx_p0 <= r_i_mem[w_eaddr][AW-1:0];
  end

  // O cache: engine writeback while busy, host writes while idle.
  always_ff @(posedge clk) begin
    if (w_wb_we)
      r_o_mem[w_wb_addr] <= w_wb[r_k];
    else if (w_cache_wr && (r_csel == DATA_W'(CSEL_O)))
      r_o_mem[w_haddr] <= DataWrite;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    neuro_mac_lane #(
      .DATA_W(DATA_W),
      .FRAC_W(FRAC_W),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_we     (w_cache_wr && (r_csel == DATA_W'(CSEL_W0 + g))),
      .i_haddr  (w_haddr),
      .i_wdata  (DataWrite),
      .i_eaddr  (w_eaddr),
      .i_l_p1   (r_l_p1),
      .i_acc_clr(w_acc_clr),
      .i_acc_en (w_acc_en),
      .o_hrdata (w_hrd[g]),
      .o_wb     (w_wb[g])
    );
  end

  // Host read selection: register space or the cache picked by CSEL.
  always_comb begin
    w_rd = '0;
    if (Address[15]) begin
      case (Address)
        REG_OFF:    w_rd = r_off;
        REG_DEST:   w_rd = r_dest;
        REG_NOPS:   w_rd = r_nops;
        REG_CSEL:   w_rd = r_csel;
        REG_CTRL:   w_rd = r_ctrl;
        REG_STATUS: begin
          w_rd[0] = ~r_ready;
          w_rd[1] = RELU_FLAG;
        end
        default:    w_rd = '0;
      endcase
    end else begin
      if (r_csel == DATA_W'(CSEL_L))      w_rd = r_l_mem[w_haddr];
      else if (r_csel == DATA_W'(CSEL_I)) w_rd = r_i_mem[w_haddr];
      else if (r_csel == DATA_W'(CSEL_O)) w_rd = r_o_mem[w_haddr];
      for (int k = 0; k < NUM_CH; k++) begin
        if (r_csel == DATA_W'(CSEL_W0 + k)) w_rd = w_hrd[k];
      end
    end
  end

  // Registered read data, one cycle after Address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) DataRead <= '0;
    else       DataRead <= w_rd;
  end

endmodule
